ca_scroll_renderer: RTL

- Parametrised 1-D elementary cellular-automaton renderer for the TinyVGA output path.
- Sits between hvsync_generator and the PMOD pin mapping. Takes pixel coordinates and produces a registered 6-bit RGB222 colour.
- Generalises the fixed single-seed renderer with:
  - configurable grid width and cell size
  - two runtime rules with per-rule colours
  - a switchable rule period
  - wrap or zero boundaries
  - single-cell or LFSR-random seeding
  - optional vertical scroll and a restart request

---
 rtl/ca_scroll_renderer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ca_scroll_renderer.sv
// ca_scroll_renderer
//   1-D elementary cellular-automaton renderer for the TinyVGA output path.
//   Each cell row of the screen shows one generation; row 0 of a frame holds
//   the frame's base generation and every following cell row is one step on.
//   Two runtime rules alternate every 2^RULE_LOG generations, each with its
//   own live-cell colour. The base row is either a single centre cell or
//   LFSR noise, and can scroll forward one generation per frame.
//
// Ports
//   clk           pixel clock
//   rst_n         synchronous active-low reset
//   pix_x, pix_y  beam position from hvsync_generator
//   video_active  display-on from hvsync_generator
//   rule_a/b      Wolfram rules for even/odd rule periods
//   color_a/b     RRGGBB live-cell colours for rule_a/rule_b
//   cfg_rand      1 = LFSR seed, 0 = single centre cell
//   cfg_wrap      1 = toroidal neighbours, 0 = outside cells read 0
//   cfg_scroll    1 = advance the base row by one generation per frame
//   restart       request a reseed at the next frame start
//   rgb           registered RRGGBB pixel (one clock after pix_x/pix_y)
//   gen           generation number of row 0 of the current frame
module ca_scroll_renderer #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          GRID_W    = 100,
    parameter int          LOG_CELL  = 2,
    parameter int          RULE_LOG  = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_active,
    input  logic [7:0]  rule_a,
    input  logic [7:0]  rule_b,
    input  logic [5:0]  color_a,
    input  logic [5:0]  color_b,
    input  logic        cfg_rand,
    input  logic        cfg_wrap,
    input  logic        cfg_scroll,
    input  logic        restart,
    output logic [5:0]  rgb,
    output logic [15:0] gen
);

    localparam int CELL = 1 << LOG_CELL;
    localparam int PAD  = (H_ACTIVE - GRID_W * CELL) / 2;
    localparam int IDXW = $clog2(GRID_W);

    localparam logic [9:0]        PAD_X    = 10'(PAD);
    localparam logic [9:0]        H_END    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_FS     = 10'(V_ACTIVE);
    localparam logic [9:0]        V_LOAD   = 10'(V_ACTIVE + 1);
    localparam logic [9:0]        GRID_W10 = 10'(GRID_W);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(GRID_W - 1);
    localparam logic [GRID_W-1:0] ONE      = GRID_W'(1);
    localparam logic [GRID_W-1:0] CENTRE   = ONE << (GRID_W / 2);

    // One generation step. lv[i]/rv[i] are the left/right neighbours of
    // cell i; the edge bits come from the far end only when wrapping.
    function automatic logic [GRID_W-1:0] ca_step(
        input logic [GRID_W-1:0] c,
        input logic [7:0]        rule,
        input logic              wrap
    );
        logic [GRID_W-1:0] lv;
        logic [GRID_W-1:0] rv;
        logic [GRID_W-1:0] n;
        lv = {c[GRID_W-2:0], wrap & c[GRID_W-1]};
        rv = {wrap & c[0], c[GRID_W-1:1]};
        for (int i = 0; i < GRID_W; i++) begin
            n[i] = rule[{lv[i], c[i], rv[i]}];
        end
        return n;
    endfunction

    typedef enum logic {S_IDLE, S_SEED} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   seed_idx;
    logic              seed_wr;
    logic [IDXW-1:0]   seed_at;

    logic [GRID_W-1:0] cur;
    logic [GRID_W-1:0] base;
    logic [GRID_W-1:0] nxt;
    logic [15:0]       gen_row;
    logic              seed_pending;
    logic [15:0]       lfsr;

    // cfg_rand and cfg_scroll are only consulted at frame start itself, the
    // instant they would be latched, so they need no shadow copy.
    logic [7:0]        sh_rule_a;
    logic [7:0]        sh_rule_b;
    logic [5:0]        sh_color_a;
    logic [5:0]        sh_color_b;
    logic              sh_wrap;

    logic [9:0]        x_off;
    logic [9:0]        cell_x;
    logic [IDXW-1:0]   cell_idx;
    logic              in_grid;
    logic              lit;
    logic              row_zero;
    logic              fs;
    logic              load_row;
    logic              ra;
    logic              reseed;
    logic              seed_go;
    logic              rule_sel;
    logic [7:0]        step_rule;
    logic [5:0]        live_color;
    logic [GRID_W-1:0] cur_step;
    logic [GRID_W-1:0] seed_mask;
    logic              lfsr_fb;

    assign x_off    = pix_x - PAD_X;
    assign cell_x   = x_off >> LOG_CELL;
    assign cell_idx = cell_x[IDXW-1:0];
    assign in_grid  = video_active & (pix_x >= PAD_X) & (cell_x < GRID_W10);
    assign lit      = in_grid & cur[cell_idx];
    assign row_zero = (pix_y >> LOG_CELL) == 10'd0;

    assign fs       = (pix_y == V_FS) & (pix_x == 10'd0);
    assign load_row = (pix_y == V_LOAD) & (pix_x == 10'd0);
    assign ra       = (pix_x == H_END) & (pix_y < V_FS) & (&pix_y[LOG_CELL-1:0]);

    assign reseed   = fs & (seed_pending | restart);
    assign seed_go  = reseed & cfg_rand;

    // Odd rule periods of the generation being shown/stepped use rule_b.
    assign rule_sel   = gen_row[RULE_LOG];
    assign step_rule  = rule_sel ? sh_rule_b : sh_rule_a;
    assign live_color = rule_sel ? sh_color_b : sh_color_a;
    assign cur_step   = ca_step(cur, step_rule, sh_wrap);

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; output is bit 0.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign seed_mask = ONE << seed_at;

    // Seed FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Seed FSM: next state. The FS cycle itself writes cell 0, SEED then
    // fills cells 1..GRID_W-1 on consecutive clocks.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (seed_go) state_nxt = S_SEED;
            S_SEED:  if (seed_idx == LAST_IDX) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Seed FSM: outputs.
    always_comb begin
        seed_wr = 1'b0;
        seed_at = '0;
        case (state)
            S_IDLE: begin
                seed_wr = seed_go;
                seed_at = '0;
            end
            S_SEED: begin
                seed_wr = 1'b1;
                seed_at = seed_idx;
            end
            default: begin
                seed_wr = 1'b0;
                seed_at = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_idx <= IDXW'(1);
        end else if (state == S_IDLE) begin
            seed_idx <= IDXW'(1);
        end else begin
            seed_idx <= seed_idx + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb          <= 6'd0;
            gen          <= 16'd0;
            gen_row      <= 16'd0;
            cur          <= '0;
            base         <= '0;
            nxt          <= '0;
            seed_pending <= 1'b1;
            lfsr         <= LFSR_SEED;
            sh_rule_a    <= 8'd0;
            sh_rule_b    <= 8'd0;
            sh_color_a   <= 6'd0;
            sh_color_b   <= 6'd0;
            sh_wrap      <= 1'b0;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};

            if (fs) begin
                sh_rule_a  <= rule_a;
                sh_rule_b  <= rule_b;
                sh_color_a <= color_a;
                sh_color_b <= color_b;
                sh_wrap    <= cfg_wrap;
            end

            // Frame-start base update: reseed beats scroll.
            if (reseed) begin
                gen <= 16'd0;
                if (!cfg_rand) begin
                    base <= CENTRE;
                end
            end else if (fs & cfg_scroll) begin
                base <= nxt;
                gen  <= gen + 16'd1;
            end

            if (seed_wr) begin
                base <= (base & ~seed_mask) | (lfsr[0] ? seed_mask : '0);
            end

            // A restart outside FS (including during SEED) waits for the next FS.
            if (reseed) begin
                seed_pending <= 1'b0;
            end else if (restart) begin
                seed_pending <= 1'b1;
            end

            if (load_row) begin
                cur     <= base;
                gen_row <= gen;
            end else if (ra) begin
                cur     <= cur_step;
                gen_row <= gen_row + 16'd1;
            end

            // Stepping out of cell row 0 yields next frame's scrolled base.
            if (ra & row_zero) begin
                nxt <= cur_step;
            end

            rgb <= lit ? live_color : 6'd0;
        end
    end

endmodule
